// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and constants for the reservation-station issue scheduler.
package rs_issue_scheduler_pkg;

    // Functional-unit class served by one scheduler instance.
    typedef enum logic [1:0] {
        RsAlu = 2'd0,
        RsLsu = 2'd1,
        RsBru = 2'd2
    } rs_type_e;

    // Physical register tag width.
    localparam int unsigned TagWidth = 5;

    // One reservation-station slot: occupancy, per-source readiness and tags.
    typedef struct packed {
        logic                     valid;
        logic [1:0]               rdy;
        logic [1:0][TagWidth-1:0] tag;
    } rs_slot_t;

endpackage

// File: rtl/rs_issue_scheduler_age_matrix.sv
// N x N age matrix: records allocation order and picks the oldest eligible slot.
// older_q[i][j] = 1 means slot i was allocated before slot j.
module rs_issue_scheduler_age_matrix #(
    parameter int unsigned NumEntries = 8,
    localparam int unsigned IdxW = $clog2(NumEntries)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NumEntries-1:0]     valid_i,
    input  logic [1:0]                alloc_valid_i,
    input  logic [1:0][IdxW-1:0]      alloc_slot_i,
    input  logic [NumEntries-1:0]     eligible_i,
    output logic [NumEntries-1:0]     grant_o
);

    logic [NumEntries-1:0][NumEntries-1:0] older_q, older_d;

    // Allocation update: clear the new slot's row, then mark every currently valid
    // slot (and a lane-0 allocation, for lane 1) as older than it.
    always_comb begin
        older_d = older_q;
        for (int k = 0; k < 2; k++) begin
            if (alloc_valid_i[k]) begin
                older_d[alloc_slot_i[k]] = '0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (alloc_valid_i[k]) begin
                for (int j = 0; j < NumEntries; j++) begin
                    older_d[j][alloc_slot_i[k]] = valid_i[j] |
                        ((k == 1) && alloc_valid_i[0] && (alloc_slot_i[0] == IdxW'(j)));
                end
            end
        end
    end

    // Oldest-of-eligible: a slot wins when no eligible slot is older than it.
    always_comb begin
        logic [NumEntries-1:0] col;
        grant_o = '0;
        for (int i = 0; i < NumEntries; i++) begin
            col = '0;
            for (int j = 0; j < NumEntries; j++) begin
                col[j] = older_q[j][i];
            end
            grant_o[i] = eligible_i[i] & ~(|(eligible_i & col));
        end
    end

    // Age state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            older_q <= '0;
        end else begin
            older_q <= older_d;
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Per-class reservation-station scheduler: slot array, wakeup CAM, oldest-ready
// select with valid/ready issue handshake, and one-cycle-delayed slot return.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
#(
    parameter int unsigned NUM_RS_ENTRIES = 8,
    parameter int unsigned TAG_W          = TagWidth,
    parameter int unsigned NUM_WAKEUP     = 2,
    parameter int unsigned TYPE           = 0,
    localparam int unsigned IDX_W         = $clog2(NUM_RS_ENTRIES)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [1:0]                       alloc_valid,
    input  logic [1:0][IDX_W-1:0]            alloc_slot,
    input  logic [1:0][1:0][TAG_W-1:0]       alloc_src_tag,
    input  logic [1:0][1:0]                  alloc_src_rdy,
    input  logic [NUM_WAKEUP-1:0]            wakeup_valid,
    input  logic [NUM_WAKEUP-1:0][TAG_W-1:0] wakeup_tag,
    input  logic                             fu_ready,
    output logic                             issue_valid,
    output logic [IDX_W-1:0]                 issue_slot,
    output logic                             free_valid,
    output logic [IDX_W:0]                   free_slot,
    output logic [IDX_W:0]                   occupancy
);

    // Slot storage is sized by the shared slot type.
    if (TAG_W != TagWidth) begin : g_bad_tag_w
        $error("TAG_W must equal the package tag width");
    end
    if (TYPE > int'(RsBru)) begin : g_bad_type
        $error("TYPE must be 0 (ALU), 1 (LSU) or 2 (BRU)");
    end

    rs_slot_t slot_q [NUM_RS_ENTRIES];
    rs_slot_t slot_d [NUM_RS_ENTRIES];

    logic [NUM_RS_ENTRIES-1:0] valid_vec;
    logic [NUM_RS_ENTRIES-1:0] eligible;
    logic [NUM_RS_ENTRIES-1:0] grant;
    logic                      fire;

    logic             free_valid_q, free_valid_d;
    logic [IDX_W-1:0] free_slot_q, free_slot_d;
    logic [IDX_W:0]   occupancy_q, occupancy_d;

    // Per-slot occupancy and readiness summary of the registered slot array.
    always_comb begin
        valid_vec = '0;
        eligible  = '0;
        for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
            valid_vec[i] = slot_q[i].valid;
            eligible[i]  = slot_q[i].valid & (&slot_q[i].rdy);
        end
    end

    rs_issue_scheduler_age_matrix #(
        .NumEntries (NUM_RS_ENTRIES)
    ) u_age_matrix (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_vec),
        .alloc_valid_i (alloc_valid),
        .alloc_slot_i  (alloc_slot),
        .eligible_i    (eligible),
        .grant_o       (grant)
    );

    // Issue offer comes from registered state only, so it never depends on fu_ready.
    always_comb begin
        issue_valid = |eligible;
        issue_slot  = '0;
        for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
            if (grant[i]) begin
                issue_slot = IDX_W'(i);
            end
        end
        fire = issue_valid & fu_ready;
    end

    // Slot array next state: wakeup, clear on fire, allocate with wakeup bypass, flush.
    always_comb begin
        for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
            slot_d[i] = slot_q[i];
        end
        for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (slot_q[i].valid && !slot_q[i].rdy[s]) begin
                    for (int w = 0; w < NUM_WAKEUP; w++) begin
                        if (wakeup_valid[w] && (wakeup_tag[w] == slot_q[i].tag[s])) begin
                            slot_d[i].rdy[s] = 1'b1;
                        end
                    end
                end
            end
        end
        for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
            if (fire && grant[i]) begin
                slot_d[i].valid = 1'b0;
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (alloc_valid[k]) begin
                slot_d[alloc_slot[k]].valid = 1'b1;
                for (int s = 0; s < 2; s++) begin
                    slot_d[alloc_slot[k]].tag[s] = alloc_src_tag[k][s];
                    slot_d[alloc_slot[k]].rdy[s] = alloc_src_rdy[k][s];
                    for (int w = 0; w < NUM_WAKEUP; w++) begin
                        if (wakeup_valid[w] && (wakeup_tag[w] == alloc_src_tag[k][s])) begin
                            slot_d[alloc_slot[k]].rdy[s] = 1'b1;
                        end
                    end
                end
            end
        end
        if (flush) begin
            for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
                slot_d[i].valid = 1'b0;
            end
        end
    end

    // Slot return pulse (suppressed by flush) and registered occupancy count.
    always_comb begin
        free_valid_d = fire & ~flush;
        free_slot_d  = free_valid_d ? issue_slot : '0;
        occupancy_d  = '0;
        for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
            occupancy_d = occupancy_d + {{IDX_W{1'b0}}, slot_d[i].valid};
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
                slot_q[i] <= '0;
            end
            free_valid_q <= 1'b0;
            free_slot_q  <= '0;
            occupancy_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_RS_ENTRIES; i++) begin
                slot_q[i] <= slot_d[i];
            end
            free_valid_q <= free_valid_d;
            free_slot_q  <= free_slot_d;
            occupancy_q  <= occupancy_d;
        end
    end

    assign free_valid = free_valid_q;
    assign free_slot  = {1'b0, free_slot_q};
    assign occupancy  = occupancy_q;

`ifndef SYNTHESIS
    // Dispatch must only target free slots, and never the same slot on both lanes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (alloc_valid[k]) begin
                    assert (!slot_q[alloc_slot[k]].valid)
                    else $error("allocation into an occupied slot");
                end
            end
            if (&alloc_valid) begin
                assert (alloc_slot[0] != alloc_slot[1])
                else $error("both lanes allocate the same slot");
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with a queue-based issue/free scoreboard.
module tb_rs_issue_scheduler;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int TW = 5;
    localparam int NW = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   flush;
    logic [1:0]             alloc_valid;
    logic [1:0][IW-1:0]     alloc_slot;
    logic [1:0][1:0][TW-1:0] alloc_src_tag;
    logic [1:0][1:0]        alloc_src_rdy;
    logic [NW-1:0]          wakeup_valid;
    logic [NW-1:0][TW-1:0]  wakeup_tag;
    logic                   fu_ready;
    logic                   issue_valid;
    logic [IW-1:0]          issue_slot;
    logic                   free_valid;
    logic [IW:0]            free_slot;
    logic [IW:0]            occupancy;

    int checks = 0;
    int errors = 0;
    int exp_issue[$];
    int exp_free[$];

    rs_issue_scheduler #(
        .NUM_RS_ENTRIES (N),
        .TAG_W          (TW),
        .NUM_WAKEUP     (NW),
        .TYPE           (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .alloc_valid   (alloc_valid),
        .alloc_slot    (alloc_slot),
        .alloc_src_tag (alloc_src_tag),
        .alloc_src_rdy (alloc_src_rdy),
        .wakeup_valid  (wakeup_valid),
        .wakeup_tag    (wakeup_tag),
        .fu_ready      (fu_ready),
        .issue_valid   (issue_valid),
        .issue_slot    (issue_slot),
        .free_valid    (free_valid),
        .free_slot     (free_slot),
        .occupancy     (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue and every free pulse must match the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (issue_valid && fu_ready && !flush) begin
                if (exp_issue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue actual=%0d required=none", issue_slot);
                end else begin
                    chk("issue_slot", 32'(issue_slot), 32'(exp_issue.pop_front()));
                end
            end
            if (free_valid) begin
                if (exp_free.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_free actual=%0d required=none", free_slot);
                end else begin
                    chk("free_slot", 32'(free_slot), 32'(exp_free.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid  = '0;
        wakeup_valid = '0;
        flush        = 1'b0;
    endtask

    task automatic set_alloc(input int lane, input int slot, input int t0, input int t1,
                             input logic [1:0] rdy);
        alloc_valid[lane]      = 1'b1;
        alloc_slot[lane]       = slot[IW-1:0];
        alloc_src_tag[lane][0] = t0[TW-1:0];
        alloc_src_tag[lane][1] = t1[TW-1:0];
        alloc_src_rdy[lane]    = rdy;
    endtask

    task automatic expect_slot(input int s);
        exp_issue.push_back(s);
        exp_free.push_back(s);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_issue.size() + exp_free.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 32'(exp_issue.size() + exp_free.size()), 32'd0);
        exp_issue.delete();
        exp_free.delete();
        tick();
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int order[8];
        order = '{3, 6, 0, 7, 1, 4, 2, 5};

        rst_n         = 1'b0;
        alloc_slot    = '0;
        alloc_src_tag = '0;
        alloc_src_rdy = '0;
        wakeup_tag    = '0;
        fu_ready      = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_issue_slot", 32'(issue_slot), 32'd0);
        chk("rst_free_valid", 32'(free_valid), 32'd0);
        chk("rst_free_slot", 32'(free_slot), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_issue_valid", 32'(issue_valid), 32'd0);

        // Basic: slot 3 ready at dispatch, issues next cycle, freed the cycle after.
        fu_ready = 1'b1;
        set_alloc(0, 3, 1, 2, 2'b11);
        expect_slot(3);
        tick();
        idle_inputs();
        chk("basic_issue_valid", 32'(issue_valid), 32'd1);
        chk("basic_issue_slot", 32'(issue_slot), 32'd3);
        chk("basic_occupancy", 32'(occupancy), 32'd1);
        tick();
        chk("basic_free_valid", 32'(free_valid), 32'd1);
        chk("basic_free_slot", 32'(free_slot), 32'd3);
        chk("basic_occ_after", 32'(occupancy), 32'd0);
        wait_drain("basic");

        // Age: lane 0 (slot 5) is older than lane 1 (slot 2).
        set_alloc(0, 5, 1, 2, 2'b11);
        set_alloc(1, 2, 1, 2, 2'b11);
        expect_slot(5);
        expect_slot(2);
        tick();
        idle_inputs();
        chk("age_first", 32'(issue_slot), 32'd5);
        wait_drain("age");

        // Wakeup: tags 7 then 9 on ports 0 and 1.
        set_alloc(0, 1, 7, 9, 2'b00);
        expect_slot(1);
        tick();
        idle_inputs();
        wakeup_valid[0] = 1'b1;
        wakeup_tag[0]   = 5'd7;
        tick();
        idle_inputs();
        wakeup_valid[1] = 1'b1;
        wakeup_tag[1]   = 5'd9;
        chk("wake_half_ready", 32'(issue_valid), 32'd0);
        tick();
        idle_inputs();
        chk("wake_issue_valid", 32'(issue_valid), 32'd1);
        chk("wake_issue_slot", 32'(issue_slot), 32'd1);
        wait_drain("wake");

        // Bypass: wakeup of tag 4 in the dispatch cycle; slot 7 still needs tag 12.
        set_alloc(0, 6, 4, 4, 2'b00);
        set_alloc(1, 7, 4, 12, 2'b00);
        wakeup_valid[0] = 1'b1;
        wakeup_tag[0]   = 5'd4;
        expect_slot(6);
        expect_slot(7);
        tick();
        idle_inputs();
        chk("bypass_issue_valid", 32'(issue_valid), 32'd1);
        chk("bypass_issue_slot", 32'(issue_slot), 32'd6);
        tick();
        chk("bypass_partial", 32'(issue_valid), 32'd0);
        wakeup_valid[1] = 1'b1;
        wakeup_tag[1]   = 5'd12;
        tick();
        idle_inputs();
        chk("bypass_late_slot", 32'(issue_slot), 32'd7);
        wait_drain("bypass");

        // Backpressure: offer held while fu_ready is low, single fire after.
        fu_ready = 1'b0;
        set_alloc(0, 0, 1, 2, 2'b11);
        tick();
        idle_inputs();
        for (int c = 0; c < 4; c++) begin
            chk("bp_issue_valid", 32'(issue_valid), 32'd1);
            chk("bp_issue_slot", 32'(issue_slot), 32'd0);
            chk("bp_no_free", 32'(free_valid), 32'd0);
            tick();
        end
        expect_slot(0);
        fu_ready = 1'b1;
        tick();
        chk("bp_free_valid", 32'(free_valid), 32'd1);
        tick();
        chk("bp_single_free", 32'(free_valid), 32'd0);
        wait_drain("bp");

        // Full: fill all slots unready, wake in reverse order, drain in age order.
        fu_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            set_alloc(0, order[2*p], 10 + order[2*p], 0, 2'b10);
            set_alloc(1, order[2*p+1], 10 + order[2*p+1], 0, 2'b10);
            tick();
        end
        idle_inputs();
        chk("full_occupancy", 32'(occupancy), 32'd8);
        chk("full_none_ready", 32'(issue_valid), 32'd0);
        for (int p = 3; p >= 0; p--) begin
            wakeup_valid  = 2'b11;
            wakeup_tag[0] = 5'(10 + order[2*p]);
            wakeup_tag[1] = 5'(10 + order[2*p+1]);
            tick();
        end
        idle_inputs();
        chk("full_oldest", 32'(issue_slot), 32'd3);
        for (int p = 0; p < 8; p++) begin
            expect_slot(order[p]);
        end
        fu_ready = 1'b1;
        wait_drain("full");
        chk("full_occ_empty", 32'(occupancy), 32'd0);

        // Flush with a fire in the same cycle and a pending free pulse.
        fu_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            set_alloc(0, 2*p, 1, 2, 2'b11);
            set_alloc(1, 2*p + 1, 1, 2, 2'b11);
            tick();
        end
        idle_inputs();
        chk("flush_occ_before", 32'(occupancy), 32'd6);
        expect_slot(0);
        fu_ready = 1'b1;
        tick();
        flush = 1'b1;
        chk("flush_pending_free", 32'(free_valid), 32'd1);
        tick();
        idle_inputs();
        fu_ready = 1'b0;
        chk("flush_occupancy", 32'(occupancy), 32'd0);
        chk("flush_issue_valid", 32'(issue_valid), 32'd0);
        chk("flush_no_free", 32'(free_valid), 32'd0);
        tick();
        chk("flush_no_free_later", 32'(free_valid), 32'd0);
        wait_drain("flush");

        // Asynchronous reset mid-operation with a free pulse in flight.
        set_alloc(0, 0, 1, 2, 2'b11);
        set_alloc(1, 1, 1, 2, 2'b11);
        tick();
        idle_inputs();
        chk("arst_occ_before", 32'(occupancy), 32'd2);
        exp_issue.push_back(0);
        fu_ready = 1'b1;
        tick();
        fu_ready = 1'b0;
        chk("arst_free_before", 32'(free_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_issue_valid", 32'(issue_valid), 32'd0);
        chk("arst_issue_slot", 32'(issue_slot), 32'd0);
        chk("arst_free_valid", 32'(free_valid), 32'd0);
        chk("arst_free_slot", 32'(free_slot), 32'd0);
        chk("arst_occupancy", 32'(occupancy), 32'd0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("arst_idle_issue", 32'(issue_valid), 32'd0);
        chk("arst_idle_occ", 32'(occupancy), 32'd0);
        wait_drain("arst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
